// File: rtl/simple_pic.sv
// Eight-line fixed-priority interrupt controller with a Wishbone register port.
// Edge-triggered requests, nested in-service tracking and vectored acknowledge.
module simple_pic #(
    parameter logic [7:0] VBASE_RST = 8'h08
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic [7:0] irq_i,
    output logic       wb_tgc_o,
    input  logic       wb_tgc_i,
    output logic [7:0] vec_o,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [1:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o
);

    logic [7:0] irq_q, irr_q, isr_q, imr_q, vec_q, dat_q;
    logic [7:0] irq_d, irr_d, isr_d, imr_d, vec_d, dat_d;
    logic [4:0] vbase_q, vbase_d;
    logic       tgc_q, tgc_d, ack_q, ack_d, block_q, block_d;

    logic [7:0] rise, pend, onehot, isr_eoi, rd_data;
    logic [2:0] cand;
    logic       found, blocked, elig, grant;
    logic       wb_sel, wr, eoi;

    always_comb begin
        rise = irq_i & ~irq_q;
        pend = irr_q & ~imr_q;
        cand = 3'd0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) begin
                cand = 3'(i);
                found = 1'b1;
            end
        end
        // Only a strictly higher-priority request may nest over service.
        blocked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) <= cand && isr_q[i]) blocked = 1'b1;
        end
        elig = found & ~blocked;
        grant = wb_tgc_i & elig;
        onehot = 8'd1 << cand;
    end

    always_comb begin
        wb_sel = wb_cyc_i & wb_stb_i & ~ack_q & ~block_q;
        wr = wb_sel & wb_we_i;
        eoi = wr && (wb_adr_i == 2'd0);
        isr_eoi = eoi ? (isr_q & (isr_q - 8'd1)) : isr_q;
        rd_data = 8'h00;
        unique case (wb_adr_i)
            2'd0: rd_data = irr_q;
            2'd1: rd_data = imr_q;
            2'd2: rd_data = isr_q;
            2'd3: rd_data = {vbase_q, 3'b000};
        endcase
    end

    always_comb begin
        irq_d = irq_i;
        irr_d = (grant ? (irr_q & ~onehot) : irr_q) | rise;
        isr_d = grant ? (isr_eoi | onehot) : isr_eoi;
        vec_d = vec_q;
        if (wb_tgc_i) vec_d = {vbase_q, grant ? cand : 3'd7};
        imr_d = (wr && wb_adr_i == 2'd1) ? wb_dat_i : imr_q;
        vbase_d = (wr && wb_adr_i == 2'd3) ? wb_dat_i[7:3] : vbase_q;
        tgc_d = elig;
        ack_d = wb_sel;
        dat_d = (wb_sel & ~wb_we_i) ? rd_data : 8'h00;
        // A strobe that straddled reset is dropped until the master releases it.
        block_d = block_q & wb_cyc_i & wb_stb_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_q   <= 8'h00;
            irr_q   <= 8'h00;
            isr_q   <= 8'h00;
            imr_q   <= 8'hFF;
            vbase_q <= VBASE_RST[7:3];
            vec_q   <= 8'h00;
            tgc_q   <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= 8'h00;
            block_q <= 1'b1;
        end else begin
            irq_q   <= irq_d;
            irr_q   <= irr_d;
            isr_q   <= isr_d;
            imr_q   <= imr_d;
            vbase_q <= vbase_d;
            vec_q   <= vec_d;
            tgc_q   <= tgc_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            block_q <= block_d;
        end
    end

    assign wb_tgc_o = tgc_q;
    assign vec_o    = vec_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_simple_pic.sv
// Directed bench for simple_pic: register access, priority, nesting,
// spurious acknowledge, edge detection and reset behaviour.
module tb_simple_pic;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_i = 8'h00;
    logic       tgc_o;
    logic       tgc_i = 1'b0;
    logic [7:0] vec_o;
    logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0] adr = 2'd0;
    logic [7:0] dat_w = 8'h00;
    logic [7:0] dat_r;
    logic       ack;

    int vecs = 0;
    int errs = 0;

    simple_pic #(.VBASE_RST(8'h08)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .irq_i    (irq_i),
        .wb_tgc_o (tgc_o),
        .wb_tgc_i (tgc_i),
        .vec_o    (vec_o),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_dat_i (dat_w),
        .wb_dat_o (dat_r),
        .wb_ack_o (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input string tag, input logic w, input logic [1:0] a,
                           input logic [7:0] d, output logic [7:0] q);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        q = 8'hxx;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (ack) break;
        end
        check({"ack_", tag}, {7'd0, ack}, 8'h01);
        q = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick(1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] q;
        wb_xfer("wr", 1'b1, a, d, q);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a,
                          input logic [7:0] exp);
        logic [7:0] q;
        wb_xfer(tag, 1'b0, a, 8'h00, q);
        check(tag, q, exp);
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_i = m;
        tick(1);
        irq_i = 8'h00;
    endtask

    task automatic iack;
        tgc_i = 1'b1;
        tick(1);
        tgc_i = 1'b0;
    endtask

    initial begin
        logic seen;
        #3;
        check("rst_tgc", {7'd0, tgc_o}, 8'h00);
        check("rst_vec", vec_o, 8'h00);
        check("rst_ack", {7'd0, ack}, 8'h00);
        check("rst_dat", dat_r, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        rd_chk("imr_rst", 2'd1, 8'hFF);
        rd_chk("vbase_rst", 2'd3, 8'h08);

        // Single request on line 0
        wr(2'd1, 8'hFE);
        pulse(8'h01);
        tick(1);
        check("t28_tgc", {7'd0, tgc_o}, 8'h01);
        rd_chk("t28_irr", 2'd0, 8'h01);
        iack();
        check("t28_vec", vec_o, 8'h08);
        rd_chk("t28_isr", 2'd2, 8'h01);
        rd_chk("t28_irr0", 2'd0, 8'h00);
        check("t28_tgc0", {7'd0, tgc_o}, 8'h00);
        wr(2'd0, 8'h00);
        rd_chk("t28_eoi", 2'd2, 8'h00);

        // Simultaneous edges, blocked lower priority, spurious ack
        wr(2'd1, 8'h00);
        pulse(8'h28);
        tick(1);
        iack();
        check("t29_vec3", vec_o, 8'h0B);
        rd_chk("t29_isr", 2'd2, 8'h08);
        iack();
        check("t29_spur", vec_o, 8'h0F);
        rd_chk("t29_irr", 2'd0, 8'h20);
        rd_chk("t29_isr2", 2'd2, 8'h08);
        wr(2'd0, 8'h00);
        rd_chk("t29_eoi", 2'd2, 8'h00);
        check("t29_tgc", {7'd0, tgc_o}, 8'h01);
        iack();
        check("t29_vec5", vec_o, 8'h0D);
        wr(2'd0, 8'h00);

        // Nesting over a lower-priority service
        pulse(8'h10);
        tick(1);
        iack();
        check("t30_vec4", vec_o, 8'h0C);
        pulse(8'h02);
        tick(1);
        check("t30_tgc", {7'd0, tgc_o}, 8'h01);
        iack();
        check("t30_vec1", vec_o, 8'h09);
        rd_chk("t30_isr", 2'd2, 8'h12);
        wr(2'd0, 8'h00);
        rd_chk("t30_eoi", 2'd2, 8'h10);
        wr(2'd0, 8'h00);
        rd_chk("t30_eoi2", 2'd2, 8'h00);

        // Vector base and edge colliding with its own acknowledge
        wr(2'd3, 8'h77);
        rd_chk("t31_vbase", 2'd3, 8'h70);
        pulse(8'h04);
        tick(1);
        iack();
        check("t31_vec", vec_o, 8'h72);
        wr(2'd0, 8'h00);
        pulse(8'h04);
        tick(1);
        irq_i = 8'h04;
        tgc_i = 1'b1;
        tick(1);
        irq_i = 8'h00;
        tgc_i = 1'b0;
        rd_chk("t31_irr", 2'd0, 8'h04);
        rd_chk("t31_isr", 2'd2, 8'h04);
        wr(2'd0, 8'h00);
        iack();
        wr(2'd0, 8'h00);
        rd_chk("t31_clr", 2'd0, 8'h00);

        // Held level sets IRR only once
        irq_i = 8'h40;
        tick(100);
        iack();
        check("t32_vec6", vec_o, 8'h76);
        rd_chk("t32_irr", 2'd0, 8'h00);
        check("t32_tgc", {7'd0, tgc_o}, 8'h00);
        irq_i = 8'h00;
        wr(2'd0, 8'h00);

        // Reset during a strobe, line 7 already high at release
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd1;
        #2;
        rst_n = 1'b0;
        irq_i = 8'h80;
        #1;
        check("rr_ack", {7'd0, ack}, 8'h00);
        check("rr_vec", vec_o, 8'h00);
        tick(2);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (ack) seen = 1'b1;
        end
        check("rr_noack", {7'd0, seen}, 8'h00);
        cyc = 1'b0; stb = 1'b0;
        tick(1);
        rd_chk("rr_imr", 2'd1, 8'hFF);
        rd_chk("rr_vbase", 2'd3, 8'h08);
        rd_chk("rr_irr", 2'd0, 8'h80);
        check("rr_tgc", {7'd0, tgc_o}, 8'h00);
        wr(2'd1, 8'h7F);
        tick(1);
        check("unmask_tgc", {7'd0, tgc_o}, 8'h01);
        iack();
        rd_chk("unmask_isr", 2'd2, 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/simple_pic.md
SIMPLE_PIC -- requirements
Module: simple_pic

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter: VBASE_RST, 8'h08, reset value of the vector base register (bits [2:0] ignored).
REQ-003 Port: wb_clk_i  input  1  system clock, all state rising-edge.
REQ-004 Port: wb_rst_ni  input  1  asynchronous active-low reset.
REQ-005 Port: irq_i  input  8  interrupt request lines from peripherals, e.g. the timer tick; synchronous to wb_clk_i; bit 0 highest priority.
REQ-006 Port: wb_tgc_o  output  1  interrupt request to CPU, level.
REQ-007 Port: wb_tgc_i  input  1  CPU interrupt acknowledge, one-cycle pulse.
REQ-008 Port: vec_o  output  8  interrupt vector, valid from the cycle after wb_tgc_i until the next acknowledge.
REQ-009 Ports: wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone slave cycle, strobe, write enable.
REQ-010 Ports: wb_adr_i  input  2  register select; wb_dat_i  input  8  write data; wb_dat_o  output  8  read data; wb_ack_o  output  1  transfer acknowledge.

Function
REQ-011 Registers: IRR (request), ISR (in-service), IMR (mask, 1 = masked), VBASE[7:3].
REQ-012 Register map: adr 0 read IRR / write any value = non-specific EOI; adr 1 IMR r/w; adr 2 read ISR, writes ignored; adr 3 VBASE r/w, bits [2:0] read 0.
REQ-013 Edge detect: per line, a registered copy of irq_i; a rising edge (irq_i=1, previous=0) sets the matching IRR bit in that cycle; a one-cycle pulse counts as an edge.
REQ-014 Level held high SHALL NOT re-set IRR after it is cleared; a new rising edge is required.
REQ-015 Candidate = lowest index n with IRR[n]=1 and IMR[n]=0; it is eligible only if no ISR bit at index <= n is set (fixed priority, nesting allowed for higher priority only).
REQ-016 wb_tgc_o SHALL be registered: high the cycle after an eligible candidate exists, low the cycle after none exists.
REQ-017 On wb_tgc_i with eligible candidate n: clear IRR[n], set ISR[n], latch vec_o = {VBASE[7:3], n[2:0]}, all at that clock edge.
REQ-018 On wb_tgc_i with no eligible candidate (spurious): vec_o = {VBASE[7:3], 3'd7}, IRR and ISR unchanged.
REQ-019 Same-cycle rising edge on line n and acknowledge clearing IRR[n]: the set wins, IRR[n] stays 1.
REQ-020 EOI clears the lowest-index set ISR bit; with ISR = 0 it has no effect.
REQ-021 EOI and acknowledge in the same cycle: EOI is evaluated on the ISR value before the acknowledge updates it.
REQ-022 Wishbone: wb_ack_o asserted one cycle after wb_cyc_i & wb_stb_i, held one cycle, then low for at least one cycle; no back-to-back ack.
REQ-023 Writes take effect at the edge where wb_ack_o is driven high; wb_dat_o is valid while wb_ack_o=1 and is 0 otherwise.
REQ-024 Masking a bit does not clear IRR; the request becomes eligible again when unmasked.

Reset
REQ-025 wb_rst_ni low SHALL immediately force IRR=0, ISR=0, IMR=8'hFF, VBASE=VBASE_RST[7:3], edge registers=0, wb_tgc_o=0, vec_o=8'h00, wb_ack_o=0, wb_dat_o=0.
REQ-026 Reset asserted mid-transfer or mid-acknowledge SHALL abandon it; no ack is produced after release for a strobe that was present during reset.
REQ-027 After release, a line already high counts as a rising edge on the first clock.

Verification
REQ-028 Write IMR=8'hFE, pulse irq_i[0] one cycle -> IRR=8'h01, wb_tgc_o=1 next cycle; wb_tgc_i -> vec_o=8'h08, ISR=8'h01, IRR=0, wb_tgc_o=0 the following cycle.
REQ-029 IMR=0, edges on irq_i[3] and irq_i[5] in the same cycle, ack -> vec_o=8'h0B; with ISR=8'h08 and no EOI, a second ack -> vec_o=8'h0F (spurious), IRR still 8'h20; EOI -> ISR=0, wb_tgc_o=1, ack -> vec_o=8'h0D.
REQ-030 ISR=8'h10 (IRQ4 in service), edge on irq_i[1] -> wb_tgc_o=1, ack -> vec_o=8'h09, ISR=8'h12; EOI -> ISR=8'h10.
REQ-031 VBASE write 8'h77 -> read back 8'h70; IRQ2 ack -> vec_o=8'h72; edge on irq_i[2] in the same cycle as its ack -> IRR[2] remains 1.
REQ-032 Hold irq_i[6] high 100 cycles with IMR=0 -> exactly one IRR set; reset pulse during a Wishbone strobe -> no ack, IMR reads 8'hFF afterwards.
